ws2812b_pixel_loader: RTL and testbench

//   Upstream feeder for the WS2812B serial driver. Accepts a valid/ready stream of
//   24-bit RGB pixels and converts each into register-bus writes (index, R, G, B) that

---
 rtl/ws2812b_pixel_loader_if.sv | 24 ++
 rtl/ws2812b_pixel_loader.sv | 153 +++++++++++++++
 tb/tb_ws2812b_pixel_loader.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812b_pixel_loader_if.sv
// Pixel stream + driver register bus bundle for ws2812b_pixel_loader.
// master: the loader (consumes the pixel stream, issues register writes).
// slave : the surrounding environment (pixel source and WS2812B driver).
interface ws2812b_pixel_loader_if;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_data;
    logic        s_last;
    logic [1:0]  reg_address;
    logic        reg_is_write;
    logic        reg_request;
    logic        reg_response;
    logic [7:0]  reg_write_data;

    modport master (
        input  s_valid, s_data, s_last, reg_response,
        output s_ready, reg_address, reg_is_write, reg_request, reg_write_data
    );

    modport slave (
        output s_valid, s_data, s_last, reg_response,
        input  s_ready, reg_address, reg_is_write, reg_request, reg_write_data
    );
endinterface

// File: rtl/ws2812b_pixel_loader.sv
// ws2812b_pixel_loader: turns a valid/ready stream of 24-bit RGB pixels into four
// register writes per pixel (COMMAND=index, R, G, B) into the WS2812B driver, with
// an auto-incrementing LED index that wraps at frame end (s_last or last LED).
// Optional feature macro: WS2812B_LOADER_BRIGHTNESS_EN adds a brightness port and
// scales every channel by (brightness+1)/256 when the pixel is accepted.
module ws2812b_pixel_loader #(
    parameter int NUMBER_OF_LEDS = 16
) (
    input  logic                  clock,
    input  logic                  resetn,
    ws2812b_pixel_loader_if.master bus,
    output logic [7:0]            led_index,
    output logic                  frame_done
`ifdef WS2812B_LOADER_BRIGHTNESS_EN
    ,
    input  logic [7:0]            brightness
`endif
);

    localparam logic [7:0] LAST_INDEX = 8'(NUMBER_OF_LEDS - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_CMD_WAIT,
        S_R,
        S_R_WAIT,
        S_G,
        S_G_WAIT,
        S_B,
        S_B_WAIT
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic             s_ready_reg;
    logic             last_reg;
    logic [7:0]       led_index_reg;
    logic             frame_done_reg;
    logic [2:0][7:0]  channel_reg;     // [0]=B, [1]=G, [2]=R
    logic [2:0][7:0]  channel_next;

    logic             accept;
    logic             pixel_done;
    logic             frame_wrap;
    logic             request;
    logic [1:0]       address;
    logic [7:0]       write_data;

    assign accept     = bus.s_valid && s_ready_reg;
    assign pixel_done = (state_reg == S_B_WAIT) && bus.reg_response;
    assign frame_wrap = last_reg || (led_index_reg == LAST_INDEX);

    // Per-channel value captured at accept; scaling happens here so the write
    // sequence itself sees a plain register and gains no latency.
    for (genvar gi = 0; gi < 3; gi++) begin : g_channel
`ifdef WS2812B_LOADER_BRIGHTNESS_EN
        assign channel_next[gi] =
            8'((16'(bus.s_data[8*gi +: 8]) * (16'(brightness) + 16'd1)) >> 8);
`else
        assign channel_next[gi] = bus.s_data[8*gi +: 8];
`endif
    end

    // State register; reset abandons any in-flight pixel.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: one request state followed by its wait state for each register,
    // COMMAND first so the driver has selected the LED before colour data arrives.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:     if (accept) state_next = S_CMD;
            S_CMD:      state_next = S_CMD_WAIT;
            S_CMD_WAIT: if (bus.reg_response) state_next = S_R;
            S_R:        state_next = S_R_WAIT;
            S_R_WAIT:   if (bus.reg_response) state_next = S_G;
            S_G:        state_next = S_G_WAIT;
            S_G_WAIT:   if (bus.reg_response) state_next = S_B;
            S_B:        state_next = S_B_WAIT;
            S_B_WAIT:   if (bus.reg_response) state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // Bus outputs decoded from state: address/data stay put through the wait state,
    // the request is high only in the single-cycle issue states.
    always_comb begin
        address    = 2'd0;
        write_data = 8'd0;
        case (state_reg)
            S_CMD, S_CMD_WAIT: begin
                address    = 2'd0;
                write_data = led_index_reg;
            end
            S_R, S_R_WAIT: begin
                address    = 2'd3;
                write_data = channel_reg[2];
            end
            S_G, S_G_WAIT: begin
                address    = 2'd2;
                write_data = channel_reg[1];
            end
            S_B, S_B_WAIT: begin
                address    = 2'd1;
                write_data = channel_reg[0];
            end
            default: begin
                address    = 2'd0;
                write_data = 8'd0;
            end
        endcase
        request = (state_reg == S_CMD) || (state_reg == S_R) ||
                  (state_reg == S_G)   || (state_reg == S_B);
    end

    // Pixel capture, ready flag, LED index and frame-end pulse.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            s_ready_reg    <= 1'b0;
            last_reg       <= 1'b0;
            led_index_reg  <= 8'd0;
            frame_done_reg <= 1'b0;
            channel_reg    <= '0;
        end else begin
            // Ready is high exactly while sitting in S_IDLE (set on entry).
            s_ready_reg    <= (state_next == S_IDLE);
            frame_done_reg <= pixel_done && frame_wrap;
            if (accept) begin
                last_reg    <= bus.s_last;
                channel_reg <= channel_next;
            end
            if (pixel_done) begin
                led_index_reg <= frame_wrap ? 8'd0 : led_index_reg + 8'd1;
            end
        end
    end

    assign bus.s_ready        = s_ready_reg;
    assign bus.reg_request    = request;
    assign bus.reg_is_write   = request;
    assign bus.reg_address    = address;
    assign bus.reg_write_data = write_data;
    assign led_index          = led_index_reg;
    assign frame_done         = frame_done_reg;

endmodule

// File: tb/tb_ws2812b_pixel_loader.sv
// Testbench for ws2812b_pixel_loader: a register-bus responder with configurable
// latency, a write/frame_done logger, and a reference model that predicts the
// write log from the pixel stream.
module tb_ws2812b_pixel_loader;

    localparam int N = 16;
    localparam logic [10:0] FD = 11'h400;   // log marker for a frame_done pulse

    logic       clock = 1'b0;
    logic       resetn;
    logic [7:0] led_index;
    logic       frame_done;
`ifdef WS2812B_LOADER_BRIGHTNESS_EN
    logic [7:0] brightness = 8'd255;
`endif

    ws2812b_pixel_loader_if bus();

    ws2812b_pixel_loader #(.NUMBER_OF_LEDS(N)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .bus        (bus),
        .led_index  (led_index),
        .frame_done (frame_done)
`ifdef WS2812B_LOADER_BRIGHTNESS_EN
        ,
        .brightness (brightness)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passes = 0;
    int resp_delay = 1;
    int model_index = 0;
    logic [10:0] got_log[$];
    logic [10:0] exp_log[$];

    // Reference: four writes per pixel, then wrap to 0 on s_last or the last LED.
    function automatic void model_pixel(input logic [23:0] px, input bit last);
        int ch[3];
        ch[0] = int'(px[23:16]);
        ch[1] = int'(px[15:8]);
        ch[2] = int'(px[7:0]);
`ifdef WS2812B_LOADER_BRIGHTNESS_EN
        for (int k = 0; k < 3; k++) ch[k] = (ch[k] * (int'(brightness) + 1)) / 256;
`endif
        exp_log.push_back({1'b0, 2'd0, 8'(model_index)});
        exp_log.push_back({1'b0, 2'd3, 8'(ch[0])});
        exp_log.push_back({1'b0, 2'd2, 8'(ch[1])});
        exp_log.push_back({1'b0, 2'd1, 8'(ch[2])});
        if (last || model_index == N - 1) begin
            exp_log.push_back(FD);
            model_index = 0;
        end else begin
            model_index++;
        end
    endfunction

    // Logger: records every request and frame_done pulse; is_write must follow request.
    always @(negedge clock) begin
        if (bus.reg_request === 1'b1) got_log.push_back({1'b0, bus.reg_address, bus.reg_write_data});
        if (frame_done === 1'b1) got_log.push_back(FD);
        checks++;
        if (bus.reg_is_write !== bus.reg_request)
            $display("FAIL is_write: got %b required %b", bus.reg_is_write, bus.reg_request);
        else passes++;
    end

    // Driver model: answers each request after resp_delay cycles, checking hold.
    initial begin : responder
        logic [1:0] a;
        logic [7:0] d;
        int         dly;
        bit         aborted;
        bus.reg_response = 1'b0;
        forever begin
            @(posedge clock); #1;
            while (bus.reg_request === 1'b1 && resetn === 1'b1) begin
                a = bus.reg_address;
                d = bus.reg_write_data;
                dly = resp_delay;
                aborted = 1'b0;
                for (int w = 1; w <= dly; w++) begin
                    @(posedge clock); #1;
                    if (resetn !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    checks++;
                    if (bus.reg_request !== 1'b0 || bus.reg_address !== a || bus.reg_write_data !== d)
                        $display("FAIL hold: got req=%b addr=%0d data=%h required req=0 addr=%0d data=%h",
                                 bus.reg_request, bus.reg_address, bus.reg_write_data, a, d);
                    else passes++;
                    if (w == dly) bus.reg_response = 1'b1;
                end
                if (!aborted) begin
                    @(posedge clock); #1;
                end
                bus.reg_response = 1'b0;
            end
        end
    end

    task automatic send_beat(input logic [23:0] px, input bit last);
        int n = 0;
        @(negedge clock);
        bus.s_valid = 1'b1;
        bus.s_data  = px;
        bus.s_last  = last;
        while (bus.s_ready !== 1'b1 && n < 300) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 300) $display("FAIL accept_timeout: got s_ready=%b required 1 within 300 cycles", bus.s_ready);
        else passes++;
        @(negedge clock);
        bus.s_valid = 1'b0;
        model_pixel(px, last);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        got_log.delete();
        exp_log.delete();
        model_index = 0;
        resetn = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic drain();
        repeat (resp_delay * 8 + 20) @(negedge clock);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (bus.s_ready !== 1'b0) $display("FAIL rst_s_ready: got %b required 0", bus.s_ready); else passes++;
        checks++; if (bus.reg_request !== 1'b0) $display("FAIL rst_request: got %b required 0", bus.reg_request); else passes++;
        checks++; if (bus.reg_is_write !== 1'b0) $display("FAIL rst_is_write: got %b required 0", bus.reg_is_write); else passes++;
        checks++; if (bus.reg_address !== 2'd0) $display("FAIL rst_address: got %0d required 0", bus.reg_address); else passes++;
        checks++; if (bus.reg_write_data !== 8'd0) $display("FAIL rst_data: got %h required 00", bus.reg_write_data); else passes++;
        checks++; if (led_index !== 8'd0) $display("FAIL rst_led_index: got %0d required 0", led_index); else passes++;
        checks++; if (frame_done !== 1'b0) $display("FAIL rst_frame_done: got %b required 0", frame_done); else passes++;
        resetn = 1'b1;
        repeat (2) @(negedge clock);
        checks++; if (bus.s_ready !== 1'b1) $display("FAIL rst_release_ready: got %b required 1", bus.s_ready); else passes++;
        got_log.delete();
    endtask

    task automatic test_single_beat();
        int n = 0;
        apply_reset();
        resp_delay = 1;
        send_beat(24'h112233, 1'b0);
        while (bus.s_ready !== 1'b1 && n < 50) begin
            n++;
            @(negedge clock);
        end
        checks++; if (n != 8) $display("FAIL single_latency: got %0d low cycles required 8", n); else passes++;
        drain();
        checks++; if (led_index !== 8'd1) $display("FAIL single_index: got %0d required 1", led_index); else passes++;
        checks++; if (got_log.size() != exp_log.size()) $display("FAIL single_log_size: got %0d required %0d", got_log.size(), exp_log.size()); else passes++;
        for (int i = 0; i < exp_log.size() && i < got_log.size(); i++) begin
            checks++; if (got_log[i] !== exp_log[i]) $display("FAIL single_log[%0d]: got %h required %h", i, got_log[i], exp_log[i]); else passes++;
        end
    endtask

    task automatic test_full_frame();
        int fd_count = 0;
        apply_reset();
        resp_delay = 1;
        for (int p = 0; p < N; p++) send_beat(24'($urandom), p == N - 1);
        drain();
        foreach (got_log[i]) if (got_log[i] === FD) fd_count++;
        checks++; if (fd_count != 1) $display("FAIL frame_fd_count: got %0d required 1", fd_count); else passes++;
        checks++; if (led_index !== 8'd0) $display("FAIL frame_index: got %0d required 0", led_index); else passes++;
        checks++; if (got_log.size() != exp_log.size()) $display("FAIL frame_log_size: got %0d required %0d", got_log.size(), exp_log.size()); else passes++;
        for (int i = 0; i < exp_log.size() && i < got_log.size(); i++) begin
            checks++; if (got_log[i] !== exp_log[i]) $display("FAIL frame_log[%0d]: got %h required %h", i, got_log[i], exp_log[i]); else passes++;
        end
    endtask

    task automatic test_short_frame();
        apply_reset();
        resp_delay = 2;
        for (int p = 0; p < 3; p++) send_beat(24'($urandom), p == 2);
        send_beat(24'($urandom), 1'b0);
        drain();
        checks++; if (led_index !== 8'd1) $display("FAIL short_index: got %0d required 1", led_index); else passes++;
        checks++; if (got_log.size() != exp_log.size()) $display("FAIL short_log_size: got %0d required %0d", got_log.size(), exp_log.size()); else passes++;
        for (int i = 0; i < exp_log.size() && i < got_log.size(); i++) begin
            checks++; if (got_log[i] !== exp_log[i]) $display("FAIL short_log[%0d]: got %h required %h", i, got_log[i], exp_log[i]); else passes++;
        end
    endtask

    task automatic test_long_frame();
        apply_reset();
        resp_delay = 1;
        for (int p = 0; p < N + 1; p++) send_beat(24'($urandom), 1'b0);
        drain();
        checks++; if (led_index !== 8'd1) $display("FAIL long_index: got %0d required 1", led_index); else passes++;
        checks++; if (got_log.size() != exp_log.size()) $display("FAIL long_log_size: got %0d required %0d", got_log.size(), exp_log.size()); else passes++;
        for (int i = 0; i < exp_log.size() && i < got_log.size(); i++) begin
            checks++; if (got_log[i] !== exp_log[i]) $display("FAIL long_log[%0d]: got %h required %h", i, got_log[i], exp_log[i]); else passes++;
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int p = 0; p < 40; p++) begin
            resp_delay = int'($urandom_range(1, 4));
            repeat ($urandom_range(0, 3)) @(negedge clock);
            send_beat(24'($urandom), ($urandom_range(0, 7) == 0));
        end
        resp_delay = 4;
        drain();
        checks++; if (led_index !== 8'(model_index)) $display("FAIL b2b_index: got %0d required %0d", led_index, model_index); else passes++;
        checks++; if (got_log.size() != exp_log.size()) $display("FAIL b2b_log_size: got %0d required %0d", got_log.size(), exp_log.size()); else passes++;
        for (int i = 0; i < exp_log.size() && i < got_log.size(); i++) begin
            checks++; if (got_log[i] !== exp_log[i]) $display("FAIL b2b_log[%0d]: got %h required %h", i, got_log[i], exp_log[i]); else passes++;
        end
    endtask

    task automatic test_delayed_reset();
        int n = 0;
        apply_reset();
        resp_delay = 5;
        send_beat(24'($urandom), 1'b0);
        send_beat(24'($urandom), 1'b0);
        send_beat(24'($urandom), 1'b0);
        // Wait for the G write of the third pixel (CMD,R,G = 3 entries after 8).
        while (got_log.size() < 11 && n < 200) begin
            @(negedge clock);
            n++;
        end
        checks++; if (n >= 200) $display("FAIL dly_g_timeout: got %0d writes required 11", got_log.size()); else passes++;
        @(negedge clock);                 // now in the G wait state
        resetn = 1'b0;
        @(negedge clock);
        checks++; if (bus.reg_request !== 1'b0) $display("FAIL dly_rst_request: got %b required 0", bus.reg_request); else passes++;
        checks++; if (bus.s_ready !== 1'b0) $display("FAIL dly_rst_ready: got %b required 0", bus.s_ready); else passes++;
        checks++; if (led_index !== 8'd0) $display("FAIL dly_rst_index: got %0d required 0", led_index); else passes++;
        checks++; if (got_log.size() != 11) $display("FAIL dly_pre_log_size: got %0d required 11", got_log.size()); else passes++;
        for (int i = 0; i < 11 && i < got_log.size(); i++) begin
            checks++; if (got_log[i] !== exp_log[i]) $display("FAIL dly_log[%0d]: got %h required %h", i, got_log[i], exp_log[i]); else passes++;
        end
        repeat (2) @(negedge clock);
        got_log.delete();
        exp_log.delete();
        model_index = 0;
        resetn = 1'b1;
        repeat (20) @(negedge clock);
        checks++; if (got_log.size() != 0) $display("FAIL dly_no_writes: got %0d writes required 0", got_log.size()); else passes++;
        send_beat(24'($urandom), 1'b0);
        drain();
        checks++; if (got_log.size() != exp_log.size()) $display("FAIL dly_post_log_size: got %0d required %0d", got_log.size(), exp_log.size()); else passes++;
        for (int i = 0; i < exp_log.size() && i < got_log.size(); i++) begin
            checks++; if (got_log[i] !== exp_log[i]) $display("FAIL dly_post_log[%0d]: got %h required %h", i, got_log[i], exp_log[i]); else passes++;
        end
    endtask

`ifdef WS2812B_LOADER_BRIGHTNESS_EN
    task automatic test_brightness();
        logic [7:0] levels[3];
        levels[0] = 8'd127;
        levels[1] = 8'd255;
        levels[2] = 8'd0;
        for (int l = 0; l < 3; l++) begin
            apply_reset();
            resp_delay = 1;
            brightness = levels[l];
            send_beat(24'hFFFFFF, 1'b0);
            send_beat(24'($urandom), 1'b0);
            drain();
            checks++; if (got_log.size() != exp_log.size()) $display("FAIL bright_log_size: got %0d required %0d", got_log.size(), exp_log.size()); else passes++;
            for (int i = 0; i < exp_log.size() && i < got_log.size(); i++) begin
                checks++; if (got_log[i] !== exp_log[i]) $display("FAIL bright_log[%0d] b=%0d: got %h required %h", i, brightness, got_log[i], exp_log[i]); else passes++;
            end
        end
        brightness = 8'd255;
    endtask
`endif

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = 24'd0;
        bus.s_last  = 1'b0;
        test_reset();
        test_single_beat();
        test_full_frame();
        test_short_frame();
        test_long_frame();
        test_back_to_back();
        test_delayed_reset();
`ifdef WS2812B_LOADER_BRIGHTNESS_EN
        test_brightness();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
